// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - default widths, buffer entry type and saturating increment
package fifo_rd_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 64;
    localparam int DEFAULT_PARITY_WIDTH  = 7;
    localparam int DEFAULT_ERR_CNT_WIDTH = 16;

    typedef struct packed {
        logic                          err;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } fifo_rd_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// rtl/fifo_rd_skid_buf.sv - DEPTH-entry circular output buffer with push/pop, occupancy and head
module fifo_rd_skid_buf import fifo_rd_pkg::*; #(
    parameter int WIDTH = $bits(fifo_rd_entry_t),
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             Clock,
    input  logic             Reset_,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Explicit wrap so non-power-of-two depths stay modulo DEPTH
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge Clock or negedge Reset_) begin
        if (!Reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_read_stage.sv
// rtl/fifo_read_stage.sv - ECC FIFO drain stage with valid/ready output and error counter
// Optional first-error syndrome log enabled by FIFO_RD_SYN_LOG_EN.
module fifo_read_stage import fifo_rd_pkg::*; #(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int PARITY_WIDTH  = DEFAULT_PARITY_WIDTH,
    parameter int BUF_DEPTH     = 2,
    parameter int ERR_CNT_WIDTH = DEFAULT_ERR_CNT_WIDTH
) (
    input  logic                     Clock,
    input  logic                     Reset_,
    input  logic                     Enable,
    input  logic                     fifo_empty_,
    input  logic [DATA_WIDTH-1:0]    fifo_data,
    input  logic                     fifo_err,
    input  logic [PARITY_WIDTH-1:0]  fifo_syndrome,
    output logic                     fifo_rd_en,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_err,
    input  logic                     err_clr,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [PARITY_WIDTH-1:0]  first_syn,
    output logic                     first_syn_vld
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int LVL_W = OCC_W + 1;
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

    logic              inflight;
    logic              pop;
    logic              err_write;
    logic [OCC_W-1:0]  occ;
    logic [LVL_W-1:0]  level;
    logic [DATA_WIDTH:0] head;

    assign pop     = m_valid & m_ready;
    assign m_valid = (occ != '0);
    assign {m_err, m_data} = head;

    // Credit: buffered plus in-flight words, less the one leaving now, must leave a free slot
    assign level      = LVL_W'(occ) + LVL_W'(inflight) - LVL_W'(pop);
    assign fifo_rd_en = Reset_ & Enable & fifo_empty_ & (level < LVL_W'(BUF_DEPTH));
    assign err_write  = inflight & fifo_err;

    always_ff @(posedge Clock or negedge Reset_) begin
        if (!Reset_) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    fifo_rd_skid_buf #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (BUF_DEPTH)
    ) u_skid_buf (
        .Clock     (Clock),
        .Reset_    (Reset_),
        .push      (inflight),
        .push_data ({fifo_err, fifo_data}),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    always_ff @(posedge Clock or negedge Reset_) begin
        if (!Reset_) begin
            err_count <= '0;
        end else if (err_write) begin
            err_count <= err_clr ? ERR_CNT_WIDTH'(1)
                                 : ERR_CNT_WIDTH'(sat_inc(32'(err_count), 32'(CNT_MAX)));
        end else if (err_clr) begin
            err_count <= '0;
        end
    end

`ifdef FIFO_RD_SYN_LOG_EN
    always_ff @(posedge Clock or negedge Reset_) begin
        if (!Reset_) begin
            first_syn     <= '0;
            first_syn_vld <= 1'b0;
        end else if (err_write && (err_clr || !first_syn_vld)) begin
            first_syn     <= fifo_syndrome;
            first_syn_vld <= 1'b1;
        end else if (err_clr) begin
            first_syn     <= '0;
            first_syn_vld <= 1'b0;
        end
    end
`else
    logic unused_syndrome;
    assign unused_syndrome = ^fifo_syndrome;
    assign first_syn       = '0;
    assign first_syn_vld   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_read_stage.sv
// tb/tb_fifo_read_stage.sv - directed self-checking bench for fifo_read_stage
module tb_fifo_read_stage;

`ifdef FIFO_RD_SYN_LOG_EN
    localparam bit SYN_EN = 1'b1;
`else
    localparam bit SYN_EN = 1'b0;
`endif

    logic        Clock;
    logic        Reset_;
    logic        Enable;
    logic        fifo_empty_;
    logic [63:0] fifo_data = '0;
    logic        fifo_err = 1'b0;
    logic [6:0]  fifo_syndrome = '0;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        m_err;
    logic        err_clr;
    logic [3:0]  err_count;
    logic [6:0]  first_syn;
    logic        first_syn_vld;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] src_data [128];
    logic        src_err  [128];
    logic [6:0]  src_syn  [128];
    int          wr_idx = 0;
    int          rd_idx = 0;

    logic [63:0] got [16];
    int          n_got;
    int          k;

    fifo_read_stage #(
        .DATA_WIDTH    (64),
        .PARITY_WIDTH  (7),
        .BUF_DEPTH     (2),
        .ERR_CNT_WIDTH (4)
    ) dut (
        .Clock         (Clock),
        .Reset_        (Reset_),
        .Enable        (Enable),
        .fifo_empty_   (fifo_empty_),
        .fifo_data     (fifo_data),
        .fifo_err      (fifo_err),
        .fifo_syndrome (fifo_syndrome),
        .fifo_rd_en    (fifo_rd_en),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_err         (m_err),
        .err_clr       (err_clr),
        .err_count     (err_count),
        .first_syn     (first_syn),
        .first_syn_vld (first_syn_vld)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [63:0] d, input logic e, input logic [6:0] s);
        src_data[wr_idx] = d;
        src_err[wr_idx]  = e;
        src_syn[wr_idx]  = s;
        wr_idx++;
    endtask

    // Source FIFO: 1-cycle synchronous read
    assign fifo_empty_ = (rd_idx < wr_idx);

    always @(posedge Clock) begin
        if (fifo_rd_en) begin
            chk("rd_en_nonempty", 64'(rd_idx < wr_idx), 64'd1);
            fifo_data     <= src_data[rd_idx];
            fifo_err      <= src_err[rd_idx];
            fifo_syndrome <= src_syn[rd_idx];
            rd_idx        <= rd_idx + 1;
        end
    end

    initial begin
        Reset_  = 1'b0;
        Enable  = 1'b1;
        m_ready = 1'b1;
        err_clr = 1'b0;
        for (int i = 1; i <= 8; i++) load(64'(i), 1'b0, 7'h00);

        repeat (3) @(negedge Clock);
        #1;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_err", m_err, 0);
        chk("rst_cnt", err_count, 0);
        chk("rst_syn", first_syn, 0);
        chk("rst_syn_vld", first_syn_vld, 0);

        // Release and stream 8 words at full rate
        Reset_ = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge Clock);
            #1;
            chk("t2_rd_en", fifo_rd_en, 64'(c < 8));
            chk("t2_valid", m_valid, 64'(c >= 2 && c < 10));
            if (c >= 2 && c < 10) chk("t2_data", m_data, 64'(c - 1));
        end

        // Back-pressure for 5 cycles mid-stream
        for (int i = 0; i < 8; i++) load(64'h11 + 64'(i), 1'b0, 7'h00);
        n_got = 0;
        for (int c = 0; c < 21; c++) begin
            if (c > 0) @(negedge Clock);
            m_ready = !(c >= 3 && c <= 7);
            #1;
            if (c >= 3 && c <= 7) begin
                chk("t3_rd_en_stall", fifo_rd_en, 0);
                chk("t3_valid_stall", m_valid, 1);
                chk("t3_data_stable", m_data, 64'h12);
            end
            if (m_valid && m_ready && n_got < 16) begin
                got[n_got] = m_data;
                n_got++;
            end
        end
        chk("t3_count", 64'(n_got), 8);
        for (int i = 0; i < 8; i++) chk("t3_order", got[i], 64'h11 + 64'(i));

        // Errors on words 3 and 6
        for (int i = 0; i < 6; i++)
            load(64'h41 + 64'(i), (i == 2 || i == 5), (i == 2) ? 7'h15 : (i == 5) ? 7'h2A : 7'h7F);
        k = 0;
        for (int c = 0; c < 13; c++) begin
            if (c > 0) @(negedge Clock);
            #1;
            if (m_valid) begin
                chk("t4_data", m_data, 64'h41 + 64'(k));
                chk("t4_err", m_err, 64'(k == 2 || k == 5));
                k++;
            end
        end
        chk("t4_words", 64'(k), 6);
        chk("t4_cnt", err_count, 2);
        chk("t4_syn", first_syn, SYN_EN ? 64'h15 : 64'h0);
        chk("t4_syn_vld", first_syn_vld, 64'(SYN_EN));

        // Saturation of a 4-bit counter, then clear coinciding with an error write
        for (int i = 0; i < 20; i++) load(64'h100 + 64'(i), 1'b1, 7'(i + 1));
        repeat (30) @(negedge Clock);
        #1;
        chk("t5_sat", err_count, 64'hF);
        chk("t5_syn_kept", first_syn, SYN_EN ? 64'h15 : 64'h0);
        @(negedge Clock);
        load(64'h5A, 1'b1, 7'h33);
        @(negedge Clock);
        err_clr = 1'b1;
        @(negedge Clock);
        err_clr = 1'b0;
        #1;
        chk("t5_clr_with_err", err_count, 1);
        chk("t5_syn_recap", first_syn, SYN_EN ? 64'h33 : 64'h0);
        chk("t5_syn_vld_recap", first_syn_vld, 64'(SYN_EN));
        @(negedge Clock);
        err_clr = 1'b1;
        @(negedge Clock);
        err_clr = 1'b0;
        #1;
        chk("t5_clr", err_count, 0);
        chk("t5_syn_clr", first_syn, 0);
        chk("t5_syn_vld_clr", first_syn_vld, 0);

        // Reset with one word buffered and one in flight
        @(negedge Clock);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(64'h61 + 64'(i), 1'b0, 7'h00);
        @(negedge Clock);
        @(negedge Clock);
        #1;
        chk("t6_pre_valid", m_valid, 1);
        chk("t6_pre_data", m_data, 64'h61);
        chk("t6_pre_rd_en", fifo_rd_en, 0);
        Reset_ = 1'b0;
        #1;
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_rd_en", fifo_rd_en, 0);
        chk("t6_rst_data", m_data, 0);
        @(negedge Clock);
        Reset_  = 1'b1;
        m_ready = 1'b1;
        #1;
        chk("t6_r0_valid", m_valid, 0);
        chk("t6_r0_rd_en", fifo_rd_en, 1);
        @(negedge Clock);
        #1;
        chk("t6_r1_valid", m_valid, 0);
        @(negedge Clock);
        #1;
        chk("t6_r2_valid", m_valid, 1);
        chk("t6_r2_data", m_data, 64'h63);

        repeat (4) @(negedge Clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
